// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer for a simple accumulator machine.
// Fetches 16-bit instructions ([15:12] opcode, [11:0] operand address),
// issues data-memory and ALU controls, handles JMP/JZ/END and halts on
// illegal opcodes.
// Optional feature: define CTRL_MUL_EN to enable the MUL opcode (3);
// without it opcode 3 is handled as an illegal instruction.
module control_unit #(
  parameter int PC_W   = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       instr,
  output logic [2:0]        alu_select,
  input  logic              z_flag,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_rd,
  output logic              dmem_wr,
  output logic              acc_we,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_MUL   = 4'h3;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JZ    = 4'h7;
  localparam logic [3:0] OP_END   = 4'hF;

  localparam logic [2:0] SEL_ADD   = 3'b000;
  localparam logic [2:0] SEL_SUB   = 3'b001;
  localparam logic [2:0] SEL_MUL   = 3'b010;
  localparam logic [2:0] SEL_PASSA = 3'b011;
  localparam logic [2:0] SEL_PASSB = 3'b100;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic [2:0]      alu_sel_q, alu_sel_d;
  logic            zreg_q, zreg_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;

  logic [3:0]      op;
  logic            mul_ok;
  logic            is_alu_op;
  logic            updates_z;
  logic [2:0]      sel_for_op;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jmp_target;

`ifdef CTRL_MUL_EN
  assign mul_ok = 1'b1;
`else
  assign mul_ok = 1'b0;
`endif

  assign op         = instr_q[15:12];
  assign is_alu_op  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_LOAD) ||
                      ((op == OP_MUL) && mul_ok);
  assign updates_z  = (op == OP_ADD) || (op == OP_SUB);
  assign pc_inc     = pc_q + PC_W'(1);
  assign jmp_target = PC_W'(instr_q[11:0]);

  // ALU operation implied by the latched opcode
  always_comb begin
    sel_for_op = SEL_PASSA;
    case (op)
      OP_ADD:   sel_for_op = SEL_ADD;
      OP_SUB:   sel_for_op = SEL_SUB;
      OP_MUL:   sel_for_op = mul_ok ? SEL_MUL : SEL_PASSA;
      OP_LOAD:  sel_for_op = SEL_PASSB;
      default:  sel_for_op = SEL_PASSA;
    endcase
  end

  // Sequencer next-state, PC, flag and ALU-select computation
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    alu_sel_d = alu_sel_q;
    zreg_d    = zreg_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          halted_d  = 1'b0;
          illegal_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // alu_select is loaded on the way into EXEC so it is presented
        // during EXEC and then simply held everywhere else
        if (is_alu_op || (op == OP_STORE)) begin
          state_d   = S_EXEC;
          alu_sel_d = sel_for_op;
        end else begin
          case (op)
            OP_NOP: begin
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end
            OP_JMP: begin
              pc_d    = jmp_target;
              state_d = S_FETCH;
            end
            OP_JZ: begin
              pc_d    = zreg_q ? jmp_target : pc_inc;
              state_d = S_FETCH;
            end
            OP_END: begin
              pc_d     = pc_inc;
              halted_d = 1'b1;
              state_d  = S_HALT;
            end
            default: begin
              halted_d  = 1'b1;
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end
          endcase
        end
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        if (updates_z) zreg_d = z_flag;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      alu_sel_q <= SEL_PASSA;
      zreg_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      alu_sel_q <= alu_sel_d;
      zreg_q    <= zreg_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign alu_select = alu_sel_q;
  assign dmem_addr  = ADDR_W'(instr_q[11:0]);
  assign dmem_rd    = (state_q == S_DECODE) && is_alu_op;
  assign dmem_wr    = (state_q == S_WB) && (op == OP_STORE);
  assign acc_we     = (state_q == S_WB) && is_alu_op;
  assign busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                      (state_q == S_EXEC)  || (state_q == S_WB);
  assign halted     = halted_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed programs push expected
// events; a negedge monitor pops and compares observed events.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] instr;
  logic [2:0]  alu_select;
  logic        z_flag;
  logic [11:0] dmem_addr;
  logic        dmem_rd;
  logic        dmem_wr;
  logic        acc_we;
  logic        busy;
  logic        halted;
  logic        illegal;

  control_unit #(.PC_W(8), .ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .instr(instr), .alu_select(alu_select), .z_flag(z_flag),
    .dmem_addr(dmem_addr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .acc_we(acc_we), .busy(busy), .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_FETCH = 0;
  localparam int K_RD    = 1;
  localparam int K_ACC   = 2;
  localparam int K_WR    = 3;
  localparam int K_HALT  = 4;

  typedef struct {
    int          k;
    logic [31:0] v;
  } ev_t;

  string       kn [5] = '{"FETCH", "RD", "ACC", "WR", "HALT"};
  ev_t         sb [$];
  logic        zq [$];
  logic        zidle;
  logic [15:0] mem [256];
  int          checks;
  int          errors;
  int          wait_cycles;
  int          wcnt;
  logic        auto_ack;
  logic        halted_prev;

  function automatic logic [31:0] av(input logic [2:0] sel, input logic [11:0] a);
    return {17'b0, sel, a};
  endfunction

  function automatic logic [31:0] hv(input logic [2:0] sel, input logic ill, input logic [7:0] a);
    return {17'b0, sel, 3'b0, ill, a};
  endfunction

  task automatic exp(input int k, input logic [31:0] v);
    ev_t e;
    e.k = k;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic see(input int k, input logic [31:0] v);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected %s: got %h, required no event", kn[k], v);
    end else begin
      e = sb.pop_front();
      if (e.k != k || e.v !== v) begin
        errors++;
        $display("FAIL event: got %s %h, required %s %h", kn[k], v, kn[e.k], e.v);
      end
    end
  endtask

  // Monitor: observe DUT output events away from the clock edge
  initial begin
    halted_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (imem_req && imem_ack) see(K_FETCH, {24'b0, imem_addr});
        if (dmem_rd) see(K_RD, {20'b0, dmem_addr});
        if (acc_we)  see(K_ACC, av(alu_select, dmem_addr));
        if (dmem_wr) see(K_WR, av(alu_select, dmem_addr));
        if (halted && !halted_prev)
          see(K_HALT, hv(alu_select, illegal, illegal ? 8'h00 : imem_addr));
      end
      halted_prev = halted;
    end
  end

  // Instruction memory responder with configurable wait states
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_ack) begin
        if (imem_req && !imem_ack) begin
          if (wcnt >= wait_cycles) begin
            imem_ack = 1'b1;
            instr    = mem[imem_addr];
            wcnt     = 0;
          end else begin
            wcnt++;
          end
        end else begin
          imem_ack = 1'b0;
        end
      end
    end
  end

  // ALU zero-flag model: per-instruction value during WB, zidle otherwise
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (acc_we) z_flag = (zq.size() > 0) ? zq.pop_front() : 1'b0;
      else        z_flag = zidle;
    end
  end

  task automatic clr_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic do_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d pending events, required 0", sb.size());
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    start    = 1'b0;
    imem_ack = 1'b0;
    auto_ack = 1'b1;
    zq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wcnt  = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_prog(input int restart_at, input int settle, output int hcyc);
    int n;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("halted_clear", halted, 1'b0);
    chk("illegal_clear", illegal, 1'b0);
    n    = 0;
    hcyc = -1;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == restart_at);
      if (halted && hcyc < 0) hcyc = n;
    end
    start = 1'b0;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending events, required 0", sb.size());
      sb.delete();
    end
    repeat (settle) begin
      @(posedge clk);
      #1;
    end
  endtask

  int hc;

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    imem_ack    = 1'b0;
    instr       = '0;
    z_flag      = 1'b0;
    zidle       = 1'b0;
    auto_ack    = 1'b1;
    wait_cycles = 1;
    wcnt        = 0;
    clr_mem();

    // Reset values
    #12;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, 8'h00);
    chk("rst_dmem_rd", dmem_rd, 1'b0);
    chk("rst_dmem_wr", dmem_wr, 1'b0);
    chk("rst_acc_we", acc_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_alu_select", alu_select, 3'b011);
    do_reset();

    // ADD then END, one-cycle ack latency; start pulsed while busy is ignored
    clr_mem();
    mem[0] = 16'h1005;
    mem[1] = 16'hF000;
    exp(K_FETCH, 32'h00);
    exp(K_RD, 32'h005);
    exp(K_ACC, av(3'b000, 12'h005));
    exp(K_FETCH, 32'h01);
    exp(K_HALT, hv(3'b000, 1'b0, 8'h02));
    run_prog(3, 4, hc);
    chk("add_halted", halted, 1'b1);
    chk("add_illegal", illegal, 1'b0);
    chk("add_busy_halt", busy, 1'b0);
    chk("add_pc", imem_addr, 8'h02);
    do_reset();

    // Zero-wait timing: two ADDs + END, 4 cycles per arithmetic instruction
    wait_cycles = 0;
    mem[1] = 16'h1006;
    mem[2] = 16'hF000;
    exp(K_FETCH, 32'h00);
    exp(K_RD, 32'h005);
    exp(K_ACC, av(3'b000, 12'h005));
    exp(K_FETCH, 32'h01);
    exp(K_RD, 32'h006);
    exp(K_ACC, av(3'b000, 12'h006));
    exp(K_FETCH, 32'h02);
    exp(K_HALT, hv(3'b000, 1'b0, 8'h03));
    run_prog(-1, 2, hc);
    chk("halt_cycles", hc, 10);
    wait_cycles = 1;
    do_reset();

    // SUB with z=1 then JZ taken
    clr_mem();
    mem[0] = 16'h2004;
    mem[1] = 16'h7020;
    zq.push_back(1'b1);
    zidle = 1'b0;
    exp(K_FETCH, 32'h00);
    exp(K_RD, 32'h004);
    exp(K_ACC, av(3'b001, 12'h004));
    exp(K_FETCH, 32'h01);
    exp(K_FETCH, 32'h20);
    exp(K_HALT, hv(3'b001, 1'b0, 8'h21));
    run_prog(-1, 3, hc);
    do_reset();

    // SUB with z=0 then JZ not taken
    zq.push_back(1'b0);
    zidle = 1'b1;
    exp(K_FETCH, 32'h00);
    exp(K_RD, 32'h004);
    exp(K_ACC, av(3'b001, 12'h004));
    exp(K_FETCH, 32'h01);
    exp(K_FETCH, 32'h02);
    exp(K_HALT, hv(3'b001, 1'b0, 8'h03));
    run_prog(-1, 3, hc);
    do_reset();

    // LOAD must not disturb zreg set by SUB; JZ still taken
    clr_mem();
    mem[0] = 16'h2004;
    mem[1] = 16'h4008;
    mem[2] = 16'h7030;
    zq.push_back(1'b1);
    zq.push_back(1'b0);
    zidle = 1'b0;
    exp(K_FETCH, 32'h00);
    exp(K_RD, 32'h004);
    exp(K_ACC, av(3'b001, 12'h004));
    exp(K_FETCH, 32'h01);
    exp(K_RD, 32'h008);
    exp(K_ACC, av(3'b100, 12'h008));
    exp(K_FETCH, 32'h02);
    exp(K_FETCH, 32'h30);
    exp(K_HALT, hv(3'b100, 1'b0, 8'h31));
    run_prog(-1, 3, hc);
    do_reset();

    // STORE: no read strobe, write strobe in WB with pass-A select
    clr_mem();
    mem[0] = 16'h500A;
    exp(K_FETCH, 32'h00);
    exp(K_WR, av(3'b011, 12'h00A));
    exp(K_FETCH, 32'h01);
    exp(K_HALT, hv(3'b011, 1'b0, 8'h02));
    run_prog(-1, 3, hc);
    do_reset();

    // Illegal opcode 9 at PC 3, then restart from HALT
    clr_mem();
    mem[0] = 16'h0000;
    mem[1] = 16'h0000;
    mem[2] = 16'h0000;
    mem[3] = 16'h9123;
    for (int r = 0; r < 2; r++) begin
      exp(K_FETCH, 32'h00);
      exp(K_FETCH, 32'h01);
      exp(K_FETCH, 32'h02);
      exp(K_FETCH, 32'h03);
      exp(K_HALT, hv(3'b011, 1'b1, 8'h00));
      run_prog(-1, 3, hc);
      chk("ill_illegal", illegal, 1'b1);
      chk("ill_halted", halted, 1'b1);
      chk("ill_busy", busy, 1'b0);
    end
    do_reset();

    // MUL depends on build configuration
    clr_mem();
    mem[0] = 16'h3007;
    exp(K_FETCH, 32'h00);
`ifdef CTRL_MUL_EN
    exp(K_RD, 32'h007);
    exp(K_ACC, av(3'b010, 12'h007));
    exp(K_FETCH, 32'h01);
    exp(K_HALT, hv(3'b010, 1'b0, 8'h02));
`else
    exp(K_HALT, hv(3'b011, 1'b1, 8'h00));
`endif
    run_prog(-1, 3, hc);
    do_reset();

    // JMP to 0xFF, NOP there wraps PC to 0
    clr_mem();
    mem[0]   = 16'h60FF;
    mem[255] = 16'h0000;
    exp(K_FETCH, 32'h00);
    exp(K_FETCH, 32'hFF);
    exp(K_FETCH, 32'h00);
    run_prog(-1, 0, hc);
    do_reset();

    // Reset during FETCH while ack arrives: no DECODE, no strobes
    clr_mem();
    mem[0]   = 16'h1005;
    auto_ack = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("mf_req", imem_req, 1'b1);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    instr    = mem[0];
    #1;
    chk("mf_req_rst", imem_req, 1'b0);
    chk("mf_busy_rst", busy, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("mf_req_after", imem_req, 1'b0);
    chk("mf_busy_after", busy, 1'b0);
    imem_ack = 1'b0;
    auto_ack = 1'b1;
    do_reset();

    // Reset during WB: acc_we drops at once, alu_select back to pass-A
    wait_cycles = 0;
    mem[0] = 16'h1005;
    exp(K_FETCH, 32'h00);
    exp(K_RD, 32'h005);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    begin
      int n;
      n = 0;
      while (!acc_we && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("wb_reached", acc_we, 1'b1);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("wb_acc_we_rst", acc_we, 1'b0);
    chk("wb_alu_rst", alu_select, 3'b011);
    chk("wb_busy_rst", busy, 1'b0);
    wait_cycles = 1;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning program-counter and instruction-address width.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning operand-address field width.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins execution from PC 0.
REQ-006 SHALL have port imem_req, output, 1, instruction fetch request.
REQ-007 SHALL have port imem_addr, output, PC_W, fetch address (current PC).
REQ-008 SHALL have port imem_ack, input, 1, fetch complete; instr valid this cycle.
REQ-009 SHALL have port instr, input, 16, instruction: [15:12] opcode, [11:0] operand address.
REQ-010 SHALL have port alu_select, output, 3, ALU operation: 000 add, 001 sub, 010 mult, 011 pass A, 100 pass B.
REQ-011 SHALL have port z_flag, input, 1, ALU zero flag; valid one cycle after alu_select applied.
REQ-012 SHALL have ports dmem_addr (output, ADDR_W), dmem_rd (output, 1) and dmem_wr (output, 1), the data-memory operand address and strobes.
REQ-013 SHALL have port acc_we, output, 1, accumulator write-enable for the registered ALU result.
REQ-014 SHALL have ports busy (output, 1), halted (output, 1) and illegal (output, 1).

Function
REQ-015 SHALL implement states IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-016 IDLE: SHALL go to FETCH on start, with PC=0 and halted/illegal cleared.
REQ-017 FETCH: SHALL hold imem_req=1 and imem_addr=PC until imem_ack; on ack latch instr and go to DECODE; an unbounded wait is legal.
REQ-018 DECODE: SHALL take one cycle, drive dmem_addr=instr[11:0], and pulse dmem_rd for opcodes 1-4.
REQ-019 Opcodes: 0 NOP, 1 ADD(sel 000), 2 SUB(001), 3 MUL(010), 4 LOAD(100), 5 STORE(011, dmem_wr), 6 JMP, 7 JZ, F END; others illegal.
REQ-020 EXEC: SHALL drive alu_select for exactly one cycle; hold alu_select unchanged in all other states (reset value 011).
REQ-021 WB: for opcodes 1-4 SHALL pulse acc_we for one cycle and latch z_flag into internal zreg; STORE pulses dmem_wr in WB.
REQ-022 ADD/SUB SHALL update zreg; MUL/LOAD/STORE SHALL leave zreg unchanged.
REQ-023 PC SHALL increment by 1 modulo 2^PC_W after every non-jump instruction; wrap from 2^PC_W-1 to 0 is legal.
REQ-024 JMP SHALL load PC=instr[PC_W-1:0]; JZ SHALL do so only if zreg=1, else increment; both skip EXEC/WB (DECODE -> FETCH).
REQ-025 NOP SHALL go DECODE -> FETCH with PC+1; END SHALL go to HALT, setting halted=1.
REQ-026 An illegal opcode SHALL go to HALT with illegal=1 and halted=1; no strobes issued.
REQ-027 HALT SHALL remain until start, which restarts from PC 0 exactly as from IDLE.
REQ-028 busy SHALL be 1 in FETCH, DECODE, EXEC and WB, and 0 otherwise.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 Per arithmetic instruction: 1 fetch cycle minimum + DECODE + EXEC + WB = 4 cycles with zero-wait ack.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, PC=0, zreg=0, and imem_req, dmem_rd, dmem_wr, acc_we, busy, halted and illegal all 0, with alu_select=011.
REQ-032 Reset asserted mid-fetch or mid-WB SHALL abort with no further strobes; a pending imem_ack after reset is ignored.

Configuration
REQ-033 Macro CTRL_MUL_EN defined: opcode 3 SHALL issue alu_select 010 per REQ-019.
REQ-034 CTRL_MUL_EN undefined: opcode 3 SHALL be treated as illegal per REQ-026, and alu_select 010 is never driven.

Verification
REQ-035 Reset release, start, program {1005, F000}, ack 1 cycle after each req -> dmem_addr=005, one acc_we, alu_select=000 in EXEC, then halted=1 with PC=2.
REQ-036 SUB with z_flag=1 at WB, then JZ 0x20 -> next imem_addr=0x20; same with z_flag=0 -> imem_addr=PC+1.
REQ-037 Opcode 9 at PC 3 -> illegal=1, halted=1, no dmem/acc strobes; start -> imem_addr=0.
REQ-038 MUL (3007) with CTRL_MUL_EN set -> alu_select=010 and one acc_we; macro cleared -> illegal=1.
REQ-039 rst_n low during FETCH while imem_ack arrives -> IDLE, imem_req=0, no DECODE entered.
REQ-040 JMP to 0xFF followed by NOP at 0xFF -> next fetch at address 0x00.
